// File: rtl/paddle_if.sv
// Mouse/game-logic side of the paddle controller: inputs from the mouse and game
// logic, paddle position and serve status back out.
interface paddle_if #(
  parameter int W = 12
);
  logic         frame_tick;
  logic [W-1:0] mouse_xpos;
  logic         mouse_left;
  logic         ball_lost;
  logic [W-1:0] xpos;
  logic [W-1:0] ypos;
  logic [W-1:0] xvel;
  logic         ball_held;
  logic         launch;

  modport master (
    output frame_tick, mouse_xpos, mouse_left, ball_lost,
    input  xpos, ypos, xvel, ball_held, launch
  );

  modport slave (
    input  frame_tick, mouse_xpos, mouse_left, ball_lost,
    output xpos, ypos, xvel, ball_held, launch
  );
endinterface

// File: rtl/paddle_ctl.sv
// Paddle controller: slew-limited tracking of mouse X once per frame, plus the
// serve FSM that holds the ball on the paddle until a left click.
module paddle_ctl #(
  parameter int W        = 12,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 600,
  parameter int Y_POS    = 500,
  parameter int START_X  = 300,
  parameter int MAX_STEP = 16
) (
  input  logic     pclk,
  input  logic     reset,
  paddle_if.slave  bus
);

  localparam logic signed [W:0] XMIN_S = (W+1)'(X_MIN);
  localparam logic signed [W:0] XMAX_S = (W+1)'(X_MAX);
  localparam logic signed [W:0] STEP_P = (W+1)'(MAX_STEP);

  typedef enum logic [1:0] {HOLD, LAUNCH, PLAY} state_t;

  state_t             state;
  logic               btn_prev;
  logic               press;
  logic signed [W:0]  mouse_s;
  logic signed [W:0]  target;
  logic signed [W:0]  delta;
  logic signed [W:0]  step;
  logic               unused_step_msb;

  // Compare in W+1 signed bits so a zero lower bound is not a constant compare.
  assign mouse_s = $signed({1'b0, bus.mouse_xpos});
  assign press   = bus.mouse_left & ~btn_prev;

  always_comb begin
    target = mouse_s;
    if (mouse_s < XMIN_S)      target = XMIN_S;
    else if (mouse_s > XMAX_S) target = XMAX_S;
    delta = target - $signed({1'b0, bus.xpos});
    step  = delta;
    if (delta > STEP_P)        step = STEP_P;
    else if (delta < -STEP_P)  step = -STEP_P;
  end

  // Both endpoints sit below 2^(W-1), so the step always fits in W bits.
  assign unused_step_msb = step[W];

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      bus.xpos <= W'(START_X);
      bus.ypos <= W'(Y_POS);
      bus.xvel <= '0;
    end else begin
      bus.ypos <= W'(Y_POS);
      if (bus.frame_tick) begin
        bus.xpos <= bus.xpos + step[W-1:0];
        bus.xvel <= step[W-1:0];
      end
    end
  end

  // btn_prev resets high so a button held through reset cannot serve.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state         <= HOLD;
      btn_prev      <= 1'b1;
      bus.ball_held <= 1'b1;
      bus.launch    <= 1'b0;
    end else begin
      btn_prev <= bus.mouse_left;
      case (state)
        HOLD: begin
          if (press) begin
            state         <= LAUNCH;
            bus.ball_held <= 1'b0;
            bus.launch    <= 1'b1;
          end
        end
        LAUNCH: begin
          state         <= PLAY;
          bus.ball_held <= 1'b0;
          bus.launch    <= 1'b0;
        end
        PLAY: begin
          if (bus.ball_lost) begin
            state         <= HOLD;
            bus.ball_held <= 1'b1;
          end
        end
        default: begin
          state         <= HOLD;
          bus.ball_held <= 1'b1;
          bus.launch    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_ctl.sv
// Directed plus random checks of paddle_ctl against a plain-arithmetic model;
// a second instance with W=10, MAX_STEP=1 runs alongside.
module tb_paddle_ctl;
  localparam int W  = 12;
  localparam int W2 = 10;

  logic pclk  = 1'b0;
  logic reset = 1'b0;
  always #5 pclk = ~pclk;

  paddle_if #(.W(W))  bus();
  paddle_if #(.W(W2)) bus2();

  paddle_ctl #(.W(W)) dut (.pclk(pclk), .reset(reset), .bus(bus));
  paddle_ctl #(.W(W2), .X_MIN(0), .X_MAX(500), .Y_POS(400), .START_X(250), .MAX_STEP(1))
    dut2 (.pclk(pclk), .reset(reset), .bus(bus2));

  int checks = 0;
  int errors = 0;

  // model: serve phase 0=held, 1=serving, 2=in play
  int m_x, m_v, m_st;
  bit m_prev;
  int m2_x, m2_v;
  int mouse2 = 0;

  function automatic int trk(input int x, input int mouse, input int lo, input int hi,
                             input int ms, output int stp);
    int t, d;
    t = (mouse < lo) ? lo : (mouse > hi) ? hi : mouse;
    d = t - x;
    stp = (d > ms) ? ms : (d < -ms) ? -ms : d;
    return x + stp;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 300; m_v = 0; m_st = 0; m_prev = 1'b1;
    m2_x = 250; m2_v = 0;
  endtask

  task automatic check_all();
    chk("xpos",      32'(bus.xpos),      32'(m_x));
    chk("ypos",      32'(bus.ypos),      32'd500);
    chk("xvel",      32'(bus.xvel),      32'(m_v) & 32'hFFF);
    chk("ball_held", 32'(bus.ball_held), 32'(m_st == 0));
    chk("launch",    32'(bus.launch),    32'(m_st == 1));
    chk("xpos2",     32'(bus2.xpos),     32'(m2_x));
    chk("xvel2",     32'(bus2.xvel),     32'(m2_v) & 32'h3FF);
    chk("xpos2_rng", 32'(bus2.xpos <= 10'd500), 32'd1);
    chk("xvel2_mag", 32'(($signed(bus2.xvel) >= -1) && ($signed(bus2.xvel) <= 1)), 32'd1);
  endtask

  task automatic step(input bit tick, input int mx, input bit left, input bit lost);
    bit press;
    bus.frame_tick  = tick;
    bus.mouse_xpos  = W'(mx);
    bus.mouse_left  = left;
    bus.ball_lost   = lost;
    bus2.frame_tick = tick;
    bus2.mouse_xpos = W2'(mouse2);
    bus2.mouse_left = 1'b0;
    bus2.ball_lost  = 1'b0;
    @(posedge pclk);
    if (tick) begin
      m_x  = trk(m_x, mx, 0, 600, 16, m_v);
      m2_x = trk(m2_x, mouse2, 0, 500, 1, m2_v);
    end
    press  = left & ~m_prev;
    m_prev = left;
    case (m_st)
      0: if (press) m_st = 1;
      1: m_st = 2;
      default: if (lost) m_st = 0;
    endcase
    #1;
    check_all();
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.mouse_xpos = '0; bus.mouse_left = 1'b1; bus.ball_lost = 1'b0;
    bus2.frame_tick = 1'b0; bus2.mouse_xpos = '0; bus2.mouse_left = 1'b0; bus2.ball_lost = 1'b0;

    // Reset with the button held; release must not serve
    repeat (2) @(posedge pclk);
    #1;
    model_reset();
    check_all();
    @(negedge pclk) reset = 1'b1;
    repeat (3) step(0, 300, 1, 0);
    step(0, 300, 0, 0);
    step(0, 300, 1, 0);
    chk("serve_launch", 32'(bus.launch), 32'd1);
    step(0, 300, 1, 0);
    chk("serve_one_cycle", 32'(bus.launch), 32'd0);

    // Slew-limited tracking 300 -> 400, hold between ticks
    for (int i = 0; i < 7; i++) begin
      step(1, 400, 1, 0);
      step(0, 400, 1, 0);
    end
    chk("track_400", 32'(bus.xpos), 32'd400);
    chk("track_last_vel", 32'(bus.xvel), 32'd4);

    // Upper clamp from 590
    for (int i = 0; i < 20 && m_x != 590; i++) step(1, 590, 1, 0);
    step(1, 4000, 1, 0);
    chk("clamp_hi_x", 32'(bus.xpos), 32'd600);
    chk("clamp_hi_v", 32'(bus.xvel), 32'd10);
    step(1, 4000, 1, 0);
    chk("clamp_hi_v0", 32'(bus.xvel), 32'd0);

    // Down to lower bound: last step -8, then settles
    for (int i = 0; i < 38; i++) step(1, 0, 1, 0);
    chk("low_last_step", 32'(bus.xvel), 32'hFF8);
    step(1, 0, 1, 0);
    chk("low_x", 32'(bus.xpos), 32'd0);
    chk("low_v", 32'(bus.xvel), 32'd0);

    // ball_lost beats a simultaneous press in PLAY
    step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    chk("lost_held", 32'(bus.ball_held), 32'd1);
    chk("lost_nolaunch", 32'(bus.launch), 32'd0);
    step(0, 0, 0, 0);
    step(1, 200, 1, 0);
    chk("relaunch", 32'(bus.launch), 32'd1);

    // Async reset during the launch cycle
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge pclk) reset = 1'b1;

    // Async reset while tracking
    mouse2 = 900;
    for (int i = 0; i < 5; i++) step(1, 100, 1, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_track_x", 32'(bus.xpos), 32'd300);
    @(negedge pclk) reset = 1'b1;

    // Random regression on both instances
    for (int i = 0; i < 400; i++) begin
      mouse2 = int'($urandom_range(0, 1023));
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
